// File: rtl/ctrl_pkg.sv
// ctrl_pkg: control-bundle bit indices, opcode values, sequencer states and opcode classification.
package ctrl_pkg;
    localparam int CTRL_W = 21;
    localparam int PCOUT = 0, ZHIGHOUT = 1, ZLOWOUT = 2, MDROUT = 3, MARIN = 4, PCIN = 5, MDRIN = 6;
    localparam int IRIN = 7, YIN = 8, ZLOWIN = 9, ZHIGHIN = 10, INCPC = 11, READ = 12, WRITE = 13;
    localparam int GRA = 14, GRB = 15, GRC = 16, RIN = 17, ROUT = 18, BAOUT = 19, COUT = 20;
    localparam int unsigned OP_LD = 0, OP_LDI = 1, OP_ST = 2, OP_R_LO = 3, OP_R_HI = 11;
    localparam int unsigned OP_NOP = 26, OP_HALT = 27;
    typedef enum logic [3:0] {
        T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
        IDLE = 4'hE, HALT = 4'hF
    } state_e;
    typedef enum logic [2:0] {K_LD, K_LDI, K_ST, K_R, K_NOP, K_HALT, K_ILL} kind_e;
    function automatic kind_e classify(input int unsigned op);
        return op == OP_LD ? K_LD : op == OP_LDI ? K_LDI : op == OP_ST ? K_ST :
               (op >= OP_R_LO && op <= OP_R_HI) ? K_R : op == OP_NOP ? K_NOP :
               op == OP_HALT ? K_HALT : K_ILL;
    endfunction
endpackage

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: start/decode/memory inputs and control/status outputs of the sequencer.
interface ctrl_sequencer_if #(parameter int OPCODE_W = 5) ();
    logic start, mem_ready, busy, illegal, mem_err;
    logic [OPCODE_W-1:0] ir_opcode, alu_op;
    logic [ctrl_pkg::CTRL_W-1:0] ctrl;
    logic [3:0] step;
    modport master(output start, ir_opcode, mem_ready, input ctrl, alu_op, step, busy, illegal, mem_err);
    modport slave(input start, ir_opcode, mem_ready, output ctrl, alu_op, step, busy, illegal, mem_err);
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts not-ready cycles of a memory wait and flags the last allowed one.
module mem_wait_timer #(parameter int MEM_TIMEOUT = 16) (
    input  logic clock,
    input  logic clear,
    input  logic restart,
    input  logic ready,
    output logic timeout
);
    logic [7:0] cnt;
    always_ff @(posedge clock or negedge clear)
        if (!clear) cnt <= '0;
        else if (restart) cnt <= '0;
        else if (!ready) cnt <= cnt + 8'd1;
    assign timeout = !restart && !ready && cnt == 8'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: T0-T7 fetch/execute control FSM with memory wait timeout and illegal-opcode halt.
module ctrl_sequencer import ctrl_pkg::*; #(
    parameter int OPCODE_W = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter logic [OPCODE_W-1:0] ALU_ADD = 5'b00011
) (
    input logic clock,
    input logic clear,
    ctrl_sequencer_if.slave bus
);
    state_e state, next;
    kind_e kind;
    logic [OPCODE_W-1:0] op_q, alu_op;
    logic [CTRL_W-1:0] ctrl;
    logic t1_entry, in_wait, timeout, idle, illegal_q, mem_err_q, mem_op, r_op, ld_op, short_op;
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) timer (
        .clock(clock), .clear(clear), .restart(!in_wait), .ready(bus.mem_ready), .timeout(timeout)
    );
    assign idle = state == IDLE || state == HALT;
    assign kind = classify(32'(state == T3 ? bus.ir_opcode : op_q));
    assign mem_op = kind == K_LD || kind == K_LDI || kind == K_ST;
    assign r_op = kind == K_R;
    assign ld_op = kind == K_LD;
    assign short_op = kind == K_LDI || r_op;
    assign in_wait = state == T1 || (state == T6 && ld_op) || (state == T7 && kind == K_ST);
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
            op_q <= '0;
            t1_entry <= 1'b0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state <= next;
            t1_entry <= state == T0;
            if (state == T3) op_q <= bus.ir_opcode;
            if (idle && bus.start) begin
                illegal_q <= 1'b0;
                mem_err_q <= 1'b0;
            end else begin
                if (state == T3 && kind == K_ILL) illegal_q <= 1'b1;
                if (timeout) mem_err_q <= 1'b1;
            end
        end
    end
    // T1 is only entered from T0, so the registered "was T0" flag marks the single PC-load cycle
    always_comb begin
        next = state;
        ctrl = '0;
        alu_op = '0;
        case (state)
            IDLE, HALT: next = bus.start ? T0 : state;
            T0: begin
                ctrl[PCOUT] = 1'b1;
                ctrl[MARIN] = 1'b1;
                ctrl[INCPC] = 1'b1;
                ctrl[ZLOWIN] = 1'b1;
                alu_op = ALU_ADD;
                next = T1;
            end
            T1: begin
                ctrl[READ] = 1'b1;
                ctrl[MDRIN] = 1'b1;
                ctrl[ZLOWOUT] = t1_entry;
                ctrl[PCIN] = t1_entry;
                next = timeout ? HALT : bus.mem_ready ? T2 : T1;
            end
            T2: begin
                ctrl[MDROUT] = 1'b1;
                ctrl[IRIN] = 1'b1;
                next = T3;
            end
            T3: begin
                ctrl[GRB] = mem_op || r_op;
                ctrl[YIN] = mem_op || r_op;
                ctrl[BAOUT] = mem_op;
                ctrl[ROUT] = r_op;
                next = (mem_op || r_op) ? T4 : kind == K_NOP ? T0 : HALT;
            end
            T4: begin
                ctrl[COUT] = mem_op;
                ctrl[GRC] = !mem_op;
                ctrl[ROUT] = !mem_op;
                ctrl[ZLOWIN] = 1'b1;
                ctrl[ZHIGHIN] = !mem_op;
                alu_op = mem_op ? ALU_ADD : op_q;
                next = T5;
            end
            T5: begin
                ctrl[ZLOWOUT] = 1'b1;
                ctrl[GRA] = short_op;
                ctrl[RIN] = short_op;
                ctrl[MARIN] = !short_op;
                next = short_op ? T0 : T6;
            end
            T6: begin
                ctrl[READ] = ld_op;
                ctrl[MDRIN] = 1'b1;
                ctrl[GRA] = !ld_op;
                ctrl[ROUT] = !ld_op;
                next = !ld_op ? T7 : timeout ? HALT : bus.mem_ready ? T7 : T6;
            end
            T7: begin
                ctrl[MDROUT] = 1'b1;
                ctrl[GRA] = ld_op;
                ctrl[RIN] = ld_op;
                ctrl[WRITE] = !ld_op;
                next = ld_op ? T0 : timeout ? HALT : bus.mem_ready ? T0 : T7;
            end
            default: next = IDLE;
        endcase
    end
    assign bus.ctrl = ctrl;
    assign bus.alu_op = alu_op;
    assign bus.step = idle ? 4'hF : state;
    assign bus.busy = !idle;
    assign bus.illegal = illegal_q;
    assign bus.mem_err = mem_err_q;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: randomized instruction streams checked cycle by cycle against a per-opcode trace model.
module tb_ctrl_sequencer;
    import ctrl_pkg::*;
    localparam int MT = 16;
    logic clk = 1'b0, clear = 1'b0;
    int tests = 0, fails = 0;
    ctrl_sequencer_if #(.OPCODE_W(5)) bus ();
    ctrl_sequencer #(.OPCODE_W(5), .MEM_TIMEOUT(MT), .ALU_ADD(5'b00011)) dut (
        .clock(clk), .clear(clear), .bus(bus)
    );
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] step;
        logic [CTRL_W-1:0] ctrl;
        logic [4:0] alu;
        logic rdy;
    } cyc_t;
    cyc_t exp_q[$];
    bit exp_halt, exp_ill, exp_err;

    function automatic logic [CTRL_W-1:0] b(input int i);
        return CTRL_W'(1) << i;
    endfunction
    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction
    function automatic void push(input int s, input logic [CTRL_W-1:0] c, input logic [4:0] a, input logic r);
        exp_q.push_back('{4'(s), c, a, r});
    endfunction
    // w not-ready cycles then ready; w >= MT means the timeout fires after MT not-ready cycles
    function automatic bit wait_phase(input int s, input logic [CTRL_W-1:0] first,
                                      input logic [CTRL_W-1:0] rest, input int w);
        if (w >= MT) begin
            for (int k = 0; k < MT; k++) push(s, k == 0 ? first : rest, 5'd0, 1'b0);
            return 1'b1;
        end
        for (int k = 0; k <= w; k++) push(s, k == 0 ? first : rest, 5'd0, k == w);
        return 1'b0;
    endfunction
    function automatic void build(input int op, input int w1, input int wm);
        exp_q.delete();
        exp_halt = 0; exp_ill = 0; exp_err = 0;
        push(0, b(PCOUT) | b(MARIN) | b(INCPC) | b(ZLOWIN), 5'b00011, rnd());
        if (wait_phase(1, b(READ) | b(MDRIN) | b(ZLOWOUT) | b(PCIN), b(READ) | b(MDRIN), w1)) begin
            exp_halt = 1; exp_err = 1; return;
        end
        push(2, b(MDROUT) | b(IRIN), 5'd0, rnd());
        if (op <= 2) begin
            push(3, b(GRB) | b(BAOUT) | b(YIN), 5'd0, rnd());
            push(4, b(COUT) | b(ZLOWIN), 5'b00011, rnd());
            if (op == 1) push(5, b(ZLOWOUT) | b(GRA) | b(RIN), 5'd0, rnd());
            else begin
                push(5, b(ZLOWOUT) | b(MARIN), 5'd0, rnd());
                if (op == 0) begin
                    if (wait_phase(6, b(READ) | b(MDRIN), b(READ) | b(MDRIN), wm)) begin
                        exp_halt = 1; exp_err = 1; return;
                    end
                    push(7, b(MDROUT) | b(GRA) | b(RIN), 5'd0, rnd());
                end else begin
                    push(6, b(GRA) | b(ROUT) | b(MDRIN), 5'd0, rnd());
                    if (wait_phase(7, b(MDROUT) | b(WRITE), b(MDROUT) | b(WRITE), wm)) begin
                        exp_halt = 1; exp_err = 1;
                    end
                end
            end
        end else if (op >= 3 && op <= 11) begin
            push(3, b(GRB) | b(ROUT) | b(YIN), 5'd0, rnd());
            push(4, b(GRC) | b(ROUT) | b(ZLOWIN) | b(ZHIGHIN), 5'(op), rnd());
            push(5, b(ZLOWOUT) | b(GRA) | b(RIN), 5'd0, rnd());
        end else begin
            push(3, '0, 5'd0, rnd());
            exp_halt = op != 26;
            exp_ill = op != 26 && op != 27;
        end
    endfunction

    task automatic check_cycle(input string name, input int i);
        tests++;
        if ({bus.step, bus.ctrl, bus.alu_op, bus.busy} !== {exp_q[i].step, exp_q[i].ctrl, exp_q[i].alu, 1'b1}) begin
            fails++;
            $display("FAIL %s cyc=%0d step/ctrl/alu/busy got %h/%h/%h/%b want %h/%h/%h/1", name, i,
                     bus.step, bus.ctrl, bus.alu_op, bus.busy, exp_q[i].step, exp_q[i].ctrl, exp_q[i].alu);
        end
    endtask
    // runs one instruction starting in T0; randomizes start (ignored while busy) and late ir_opcode
    task automatic run(input int op, input int w1, input int wm);
        build(op, w1, wm);
        bus.ir_opcode = 5'(op);
        foreach (exp_q[i]) begin
            check_cycle($sformatf("run_op%0d", op), i);
            bus.mem_ready = exp_q[i].rdy;
            bus.start = rnd();
            if (exp_q[i].step >= 4) bus.ir_opcode = 5'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        tests++;
        if ({bus.step, bus.busy, bus.illegal, bus.mem_err} !== {exp_halt ? 4'hF : 4'h0, !exp_halt, exp_ill, exp_err}) begin
            fails++;
            $display("FAIL end_op%0d step/busy/illegal/mem_err got %h/%b/%b/%b want %h/%b/%b/%b", op,
                     bus.step, bus.busy, bus.illegal, bus.mem_err, exp_halt ? 4'hF : 4'h0, !exp_halt, exp_ill, exp_err);
        end
    endtask
    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        tests++;
        if ({bus.step, bus.busy, bus.illegal, bus.mem_err} !== {4'h0, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL start step/busy/illegal/mem_err got %h/%b/%b/%b want 0/1/0/0",
                     bus.step, bus.busy, bus.illegal, bus.mem_err);
        end
    endtask
    task automatic check_idle(input string name);
        tests++;
        if ({bus.step, bus.busy, bus.ctrl, bus.alu_op} !== {4'hF, 1'b0, CTRL_W'(0), 5'd0}) begin
            fails++;
            $display("FAIL %s step/busy/ctrl/alu got %h/%b/%h/%h want f/0/0/0", name, bus.step, bus.busy, bus.ctrl, bus.alu_op);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.mem_ready = 1'b0; bus.ir_opcode = 5'd0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        tests++;
        if ({bus.illegal, bus.mem_err} !== 2'b00) begin
            fails++;
            $display("FAIL reset_flags got %b%b want 00", bus.illegal, bus.mem_err);
        end
        bus.start = 1'b1;
        @(negedge clk);
        check_idle("start_in_reset");
        bus.start = 1'b0; clear = 1'b1;
        @(negedge clk);
        check_idle("after_release");
    endtask
    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = rnd();
            @(negedge clk);
            check_idle("idle_hold");
        end
    endtask
    task automatic test_directed();
        do_start();
        run(0, 0, 0);
        run(0, 0, 0);
        run(0, 3, 2);
        run(3, 0, 0);
        run(2, 0, 1);
        run(1, 2, 0);
        run(26, 0, 0);
        run(31, 0, 0);
        do_start();
        run(11, 1, 0);
        run(27, 0, 0);
        do_start();
        run(0, MT, 0);
        do_start();
        run(0, 1, MT);
        do_start();
        run(2, 0, MT + 3);
        do_start();
    endtask
    task automatic test_random();
        int legal[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 26};
        int op, w1, wm;
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : legal[$urandom_range(0, 12)];
            w1 = ($urandom_range(0, 15) == 0) ? MT : int'($urandom_range(0, 4));
            wm = ($urandom_range(0, 15) == 0) ? MT : int'($urandom_range(0, 4));
            run(op, w1, wm);
            if (exp_halt) do_start();
        end
    endtask
    task automatic test_clear();
        build(0, 0, 0);
        bus.ir_opcode = 5'd0;
        for (int i = 0; i <= 5; i++) begin
            check_cycle("clear_pre", i);
            bus.mem_ready = exp_q[i].rdy;
            if (i < 5) @(negedge clk);
        end
        #2 clear = 1'b0;
        #1 check_idle("clear_async");
        tests++;
        if ({bus.illegal, bus.mem_err} !== 2'b00) begin
            fails++;
            $display("FAIL clear_flags got %b%b want 00", bus.illegal, bus.mem_err);
        end
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        check_idle("clear_release");
        do_start();
        run(4, 0, 0);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_directed();
        test_random();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
